// File: rtl/led_out_sched_pkg.sv
// Shared register map and arbiter state encoding for led_out_sched.
package led_out_sched_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_BLINK  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_ALARM   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink prescaler: counts 0..period and toggles phase on each wrap.
module led_blink_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  enable,
  input  logic                  restart,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    // A restart takes priority over a wrap in the same cycle.
    if (restart || !enable || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_out_sched.sv
// LED output scheduler: Avalon-MM register file, blink masking and an optional
// alarm ownership arbiter (enabled by defining LED_OUT_SCHED_ALARM_EN).
module led_out_sched
  import led_out_sched_pkg::*;
#(
  parameter int NUM_LEDS   = 6,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                alarm_req,
  input  logic [NUM_LEDS-1:0] alarm_pattern,
  output logic                alarm_gnt,
  output logic [NUM_LEDS-1:0] out_port
);

  logic [NUM_LEDS-1:0]   data_q, blink_q, out_q, out_d, cpu_view;
  logic [PRESCALE_W-1:0] period_q;
  logic                  blink_en_q;
  logic                  phase;
  logic                  wr_en, restart;
  logic                  wdata_unused;

  assign wr_en        = chipselect && !write_n;
  assign restart      = wr_en && ((address == ADDR_PERIOD) || (address == ADDR_CTRL));
  assign wdata_unused = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      blink_q    <= '0;
      period_q   <= '0;
      blink_en_q <= 1'b0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_q     <= writedata[NUM_LEDS-1:0];
        ADDR_BLINK:  blink_q    <= writedata[NUM_LEDS-1:0];
        ADDR_PERIOD: period_q   <= writedata[PRESCALE_W-1:0];
        default:     blink_en_q <= writedata[0];
      endcase
    end
  end

  led_blink_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .period  (period_q),
    .enable  (blink_en_q),
    .restart (restart),
    .phase   (phase)
  );

  // Masked LEDs go dark during the low half of the blink phase.
  assign cpu_view = data_q & ~(blink_q & {NUM_LEDS{~phase}});

`ifdef LED_OUT_SCHED_ALARM_EN
  arb_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    out_d   = cpu_view;
    case (state_q)
      ST_CPU: begin
        if (alarm_req) state_d = ST_ALARM;
      end
      ST_ALARM: begin
        out_d = alarm_pattern;
        if (!alarm_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        out_d   = out_q;
        state_d = ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CPU;
    else       state_q <= state_d;
  end

  assign alarm_gnt = (state_q == ST_ALARM);
`else
  logic alarm_unused;

  assign alarm_unused = alarm_req ^ (^alarm_pattern);
  assign alarm_gnt    = 1'b0;
  assign out_d        = cpu_view;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[NUM_LEDS-1:0]   = data_q;
      ADDR_BLINK:  readdata[NUM_LEDS-1:0]   = blink_q;
      ADDR_PERIOD: readdata[PRESCALE_W-1:0] = period_q;
      default:     readdata[2:0]            = {alarm_gnt, phase, blink_en_q};
    endcase
  end

endmodule

// File: tb/tb_led_out_sched.sv
// Directed self-checking bench for led_out_sched; alarm scenarios run only
// when LED_OUT_SCHED_ALARM_EN is defined, otherwise the disabled-alarm path.
module tb_led_out_sched;

  localparam int NUM_LEDS   = 6;
  localparam int PRESCALE_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          address;
  logic                chipselect;
  logic                write_n;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                alarm_req;
  logic [NUM_LEDS-1:0] alarm_pattern;
  logic                alarm_gnt;
  logic [NUM_LEDS-1:0] out_port;

  int n_cmp = 0;
  int n_bad = 0;

  led_out_sched #(.NUM_LEDS(NUM_LEDS), .PRESCALE_W(PRESCALE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .alarm_req     (alarm_req),
    .alarm_pattern (alarm_pattern),
    .alarm_gnt     (alarm_gnt),
    .out_port      (out_port)
  );

  always #5 clk = ~clk;

  // Write lands on the posedge between the two negedges; returns at the second.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    address       = 2'd0;
    chipselect    = 1'b0;
    write_n       = 1'b1;
    writedata     = '0;
    alarm_req     = 1'b0;
    alarm_pattern = '0;
    #12;
    n_cmp++; if (out_port !== 6'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", out_port); end
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0", alarm_gnt); end
    for (int a = 0; a < 3; a++) begin
      address = a[1:0]; #1;
      n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rd%0d: got %h want 00000000", a, readdata); end
    end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL reset_ctrl: got %h want 00000002", readdata); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h00) begin n_bad++; $display("FAIL reset_hold: got %h want 00", out_port); end
  endtask

  task automatic test_data_write;
    write_reg(2'd0, 32'h2A);
    n_cmp++; if (out_port !== 6'h00) begin n_bad++; $display("FAIL data_latency: got %h want 00", out_port); end
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h2A) begin n_bad++; $display("FAIL data_out: got %h want 2a", out_port); end
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h0000002A) begin n_bad++; $display("FAIL data_rd: got %h want 0000002a", readdata); end
    write_reg(2'd0, 32'hFFFF_FFC5);
    @(negedge clk);
    address = 2'd0; #1;
    n_cmp++; if (readdata !== 32'h00000005) begin n_bad++; $display("FAIL data_trunc: got %h want 00000005", readdata); end
  endtask

  task automatic test_blink;
    logic [5:0]  exp_out;
    logic [31:0] exp_ctrl;
    write_reg(2'd0, 32'h3F);
    write_reg(2'd1, 32'h03);
    write_reg(2'd2, 32'h4);
    address = 2'd1; #1;
    n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL blink_rd_mask: got %h want 00000003", readdata); end
    address = 2'd2; #1;
    n_cmp++; if (readdata !== 32'h4) begin n_bad++; $display("FAIL blink_rd_period: got %h want 00000004", readdata); end
    write_reg(2'd3, 32'hFFFF_FFF1);
    address = 2'd3;
    // Phase after CTRL-write edge k is high for k/5 even; out_port lags a cycle.
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      exp_out  = ((((k - 1) / 5) % 2) == 0) ? 6'h3F : 6'h3C;
      exp_ctrl = {30'd0, (((k / 5) % 2) == 0), 1'b1};
      n_cmp++; if (out_port !== exp_out) begin n_bad++; $display("FAIL blink_out k=%0d: got %h want %h", k, out_port, exp_out); end
      n_cmp++; if (readdata !== exp_ctrl) begin n_bad++; $display("FAIL blink_ctrl k=%0d: got %h want %h", k, readdata, exp_ctrl); end
    end
  endtask

  task automatic test_period_zero;
    write_reg(2'd2, 32'h0);
    n_cmp++; if (out_port !== 6'h3C) begin n_bad++; $display("FAIL pz_prev: got %h want 3c", out_port); end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL pz_phase: got %h want 00000003", readdata); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (out_port !== 6'h3F) begin n_bad++; $display("FAIL pz_steady k=%0d: got %h want 3f", k, out_port); end
    end
  endtask

  task automatic test_restart;
    write_reg(2'd2, 32'h2);
    repeat (3) @(negedge clk);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL rs_low: got %h want 00000001", readdata); end
    write_reg(2'd3, 32'h1);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL rs_restart: got %h want 00000003", readdata); end
    write_reg(2'd3, 32'h0);
    repeat (4) @(negedge clk);
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL rs_disabled: got %h want 00000002", readdata); end
    n_cmp++; if (out_port !== 6'h3F) begin n_bad++; $display("FAIL rs_out: got %h want 3f", out_port); end
  endtask

`ifdef LED_OUT_SCHED_ALARM_EN
  task automatic test_alarm;
    @(negedge clk);
    alarm_req     = 1'b1;
    alarm_pattern = 6'h15;
    @(negedge clk);
    n_cmp++; if (alarm_gnt !== 1'b1) begin n_bad++; $display("FAIL al_gnt: got %b want 1", alarm_gnt); end
    n_cmp++; if (out_port !== 6'h3F) begin n_bad++; $display("FAIL al_pre: got %h want 3f", out_port); end
    write_reg(2'd0, 32'h0F);
    n_cmp++; if (out_port !== 6'h15) begin n_bad++; $display("FAIL al_out: got %h want 15", out_port); end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h6) begin n_bad++; $display("FAIL al_ctrl: got %h want 00000006", readdata); end
    alarm_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL al_drop: got %b want 0", alarm_gnt); end
    n_cmp++; if (out_port !== 6'h15) begin n_bad++; $display("FAIL al_last: got %h want 15", out_port); end
    alarm_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h15) begin n_bad++; $display("FAIL al_hold: got %h want 15", out_port); end
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL al_rel_gnt: got %b want 0", alarm_gnt); end
    alarm_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h0F) begin n_bad++; $display("FAIL al_resume: got %h want 0f", out_port); end
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL al_req_ignored: got %b want 0", alarm_gnt); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    address       = 2'd0;
    writedata     = 32'h11;
    chipselect    = 1'b1;
    write_n       = 1'b0;
    alarm_req     = 1'b1;
    alarm_pattern = 6'h2A;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
    n_cmp++; if (alarm_gnt !== 1'b1) begin n_bad++; $display("FAIL bb_gnt: got %b want 1", alarm_gnt); end
    n_cmp++; if (readdata !== 32'h11) begin n_bad++; $display("FAIL bb_data: got %h want 00000011", readdata); end
  endtask

  task automatic test_reset_mid_alarm;
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h2A) begin n_bad++; $display("FAIL rm_pre: got %h want 2a", out_port); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_port !== 6'h00) begin n_bad++; $display("FAIL rm_out: got %h want 00", out_port); end
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_gnt: got %b want 0", alarm_gnt); end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL rm_held: got %b want 0", alarm_gnt); end
    @(negedge clk);
    n_cmp++; if (alarm_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_regrant: got %b want 1", alarm_gnt); end
    alarm_req = 1'b0;
  endtask
`else
  task automatic test_alarm_disabled;
    alarm_req     = 1'b1;
    alarm_pattern = 6'h15;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL dis_gnt k=%0d: got %b want 0", k, alarm_gnt); end
      n_cmp++; if (out_port !== 6'h3F) begin n_bad++; $display("FAIL dis_out k=%0d: got %h want 3f", k, out_port); end
    end
    address = 2'd3; #1;
    n_cmp++; if (readdata !== 32'h2) begin n_bad++; $display("FAIL dis_ctrl: got %h want 00000002", readdata); end
    write_reg(2'd0, 32'h2A);
    @(negedge clk);
    n_cmp++; if (out_port !== 6'h2A) begin n_bad++; $display("FAIL dis_data: got %h want 2a", out_port); end
    n_cmp++; if (alarm_gnt !== 1'b0) begin n_bad++; $display("FAIL dis_gnt_end: got %b want 0", alarm_gnt); end
    alarm_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_data_write;
    test_blink;
    test_period_zero;
    test_restart;
`ifdef LED_OUT_SCHED_ALARM_EN
    test_alarm;
    test_back_to_back;
    test_reset_mid_alarm;
`else
    test_alarm_disabled;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_out_sched.md
LED_OUT_SCHED -- requirements
Module: led_out_sched

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 6, LED output width; legal range 1..32.
REQ-002 SHALL have parameter PRESCALE_W, default 16, blink prescaler and PERIOD register width; legal range 1..32.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data; combinational, zero wait states.
REQ-010 SHALL have port alarm_req  input  1  hardware requester asks to own the LEDs.
REQ-011 SHALL have port alarm_pattern  input  NUM_LEDS  pattern driven while alarm owns the LEDs.
REQ-012 SHALL have port alarm_gnt  output  1  ownership grant to the alarm requester.
REQ-013 SHALL have port out_port  output  NUM_LEDS  registered LED drive.

Function
REQ-014 SHALL write a register when chipselect=1 and write_n=0; address 0 DATA[NUM_LEDS-1:0], 1 BLINK_MASK[NUM_LEDS-1:0], 2 PERIOD[PRESCALE_W-1:0], 3 CTRL (bit0 blink_en; other bits ignored).
REQ-015 SHALL return on readdata, zero-extended: address 0 DATA, 1 BLINK_MASK, 2 PERIOD, 3 {alarm_gnt at bit 2, phase at bit 1, blink_en at bit 0}; all unused bits 0.
REQ-016 SHALL run prescaler cnt: when blink_en=1 and PERIOD!=0, cnt increments each cycle; when cnt==PERIOD, cnt wraps to 0 and phase toggles. Half-period is PERIOD+1 cycles.
REQ-017 SHALL hold cnt=0 and phase=1 whenever blink_en=0 or PERIOD=0.
REQ-018 SHALL reset cnt=0 and phase=1 in the cycle after any write to PERIOD or CTRL; the write has priority over wrap.
REQ-019 SHALL compute cpu_view = DATA & ~(BLINK_MASK & {NUM_LEDS{~phase}}).
REQ-020 SHALL implement the arbiter FSM with states CPU, ALARM and RELEASE.
REQ-021 SHALL transition CPU->ALARM when alarm_req=1, ALARM->RELEASE when alarm_req=0, and RELEASE->CPU unconditionally after 1 cycle; alarm_req in RELEASE is ignored until CPU is re-entered.
REQ-022 SHALL drive alarm_gnt=1 exactly in state ALARM (registered), so the grant follows alarm_req by 1 cycle.
REQ-023 SHALL load out_port each cycle with alarm_pattern in ALARM, hold it in RELEASE, and load cpu_view in CPU; a change is visible on out_port 1 edge after the causing edge.
REQ-024 SHALL keep accepting register writes and advancing the prescaler during ALARM, so that CPU state resumes with current values.
REQ-025 SHALL give a simultaneous CPU write and alarm_req precedence as follows: the write updates its register and the FSM still moves to ALARM.

Reset
REQ-026 SHALL, on reset assertion, asynchronously force DATA=0, BLINK_MASK=0, PERIOD=0, blink_en=0, cnt=0, phase=1, state=CPU, alarm_gnt=0, out_port=0.
REQ-027 SHALL, on reset mid-ALARM, drop alarm_gnt immediately; after release, a still-high alarm_req is granted 1 cycle after the first clock edge.

Configuration
REQ-028 SHALL, when macro LED_OUT_SCHED_ALARM_EN is defined, include the arbiter FSM and alarm ports' function.
REQ-029 SHALL, without LED_OUT_SCHED_ALARM_EN, keep the alarm ports present, ignore alarm_req/alarm_pattern, tie alarm_gnt=0, read CTRL bit 2 as 0, and make out_port follow cpu_view only.

Structure
REQ-030 SHALL place the register address constants (ADDR_DATA=0, ADDR_BLINK=1, ADDR_PERIOD=2, ADDR_CTRL=3) and the FSM state encoding in shared package led_out_sched_pkg.
REQ-031 SHALL implement the prescaler/phase logic as sub-module led_blink_prescaler (ports clk, reset, period, enable, restart, phase).

Verification
REQ-032 SHALL cover: reset, then write DATA=0x2A -> out_port=0x2A 1 cycle later; readdata at address 0 = 0x0000002A.
REQ-033 SHALL cover: DATA=0x3F, BLINK_MASK=0x03, PERIOD=4, CTRL=1 -> bits[1:0] toggle every 5 cycles and bits[5:2] stay 1.
REQ-034 SHALL cover: alarm_req=1 with alarm_pattern=0x15 -> alarm_gnt=1 after 1 cycle and out_port=0x15; alarm_req=0 -> gnt=0 next cycle, 0x15 held 1 cycle, then cpu_view.
REQ-035 SHALL cover: write PERIOD=0 while blinking -> phase=1 and all masked LEDs steady on.
REQ-036 SHALL cover: reset asserted mid-ALARM -> out_port=0 and alarm_gnt=0 without a clock edge.
REQ-037 SHALL cover: a build without LED_OUT_SCHED_ALARM_EN with alarm_req=1 -> alarm_gnt stays 0 and out_port=DATA.
